// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative, write-back, write-allocate cache.
// One request is in flight at a time. A miss picks a victim (lowest invalid
// way, else the set's round-robin pointer), writes it back if dirty, then
// fills the line from the line-wide memory port.
module set_assoc_cache #(
    parameter int ADDR_W         = 64,
    parameter int LOG_LINE_BYTES = 6,
    parameter int WORD_W         = 64,
    parameter int LOG_WAYS       = 2,
    parameter int LOG_SETS       = 5,
    localparam int LINE_W        = 8 << LOG_LINE_BYTES,
    localparam int NWORDS        = LINE_W / WORD_W,
    localparam int TAG_W         = ADDR_W - LOG_SETS - LOG_LINE_BYTES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    input  logic [NWORDS-1:0] req_wen,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data
);

    localparam int WAYS = 1 << LOG_WAYS;
    localparam int SETS = 1 << LOG_SETS;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] WB_REQ    = 3'd2;
    localparam logic [2:0] FILL_REQ  = 3'd3;
    localparam logic [2:0] FILL_WAIT = 3'd4;
    localparam logic [2:0] RESPOND   = 3'd5;

    // Cache arrays: tags and data per way/set, status bits per set.
    logic [TAG_W-1:0]    tag_arr_q [WAYS][SETS];
    logic [LINE_W-1:0]   data_q    [WAYS][SETS];
    logic [WAYS-1:0]     valid_q   [SETS];
    logic [WAYS-1:0]     dirty_q   [SETS];
    logic [LOG_WAYS-1:0] ptr_q     [SETS];

    // Control state and the latched request.
    logic [2:0]          state_q, state_d;
    logic                write_q;
    logic [TAG_W-1:0]    tag_q;
    logic [LOG_SETS-1:0] index_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [NWORDS-1:0]   wen_q;
    logic [LOG_WAYS-1:0] victim_q;
    logic                victim_by_ptr_q;
    logic [LINE_W-1:0]   resp_data_q;

    // Lookup results.
    logic                hit;
    logic [LOG_WAYS-1:0] hit_way;
    logic                inv_found;
    logic [LOG_WAYS-1:0] inv_way;
    logic [LOG_WAYS-1:0] victim_sel;
    logic                eff_write;
    logic [LINE_W-1:0]   hit_result;
    logic [LINE_W-1:0]   fill_result;
    logic [LINE_W-1:0]   victim_line;
    logic [TAG_W-1:0]    victim_tag;

    // Byte-offset bits never select anything: whole lines move everywhere.
    logic unused_offset;
    assign unused_offset = ^req_addr[LOG_LINE_BYTES-1:0];

    function automatic logic [LINE_W-1:0] merge_words(input logic [LINE_W-1:0] base,
                                                      input logic [LINE_W-1:0] wd,
                                                      input logic [NWORDS-1:0] en);
        merge_words = base;
        for (int i = 0; i < NWORDS; i++) begin
            if (en[i]) merge_words[i*WORD_W +: WORD_W] = wd[i*WORD_W +: WORD_W];
        end
    endfunction

    // Tag match across ways and lowest-index invalid way of the addressed set.
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise paths that skip an assignment infer latches.
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[index_q][w] && tag_arr_q[w][index_q] == tag_q) begin
                hit     = 1'b1;
                hit_way = LOG_WAYS'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[index_q][w]) begin
                inv_found = 1'b1;
                inv_way   = LOG_WAYS'(w);
            end
        end
    end

    assign victim_sel  = inv_found ? inv_way : ptr_q[index_q];
    assign eff_write   = write_q && (|wen_q);
    assign hit_result  = write_q ? merge_words(data_q[hit_way][index_q], wdata_q, wen_q)
                                 : data_q[hit_way][index_q];
    assign fill_result = write_q ? merge_words(mem_resp_data, wdata_q, wen_q) : mem_resp_data;
    assign victim_line = data_q[victim_q][index_q];
    assign victim_tag  = tag_arr_q[victim_q][index_q];

    // Next-state logic for the miss-handling FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_valid) state_d = LOOKUP;
            LOOKUP: begin
                if (hit)                                 state_d = RESPOND;
                else if (dirty_q[index_q][victim_sel])   state_d = WB_REQ;
                else                                     state_d = FILL_REQ;
            end
            WB_REQ:    if (mem_req_ready)  state_d = FILL_REQ;
            FILL_REQ:  if (mem_req_ready)  state_d = FILL_WAIT;
            FILL_WAIT: if (mem_resp_valid) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM, request latch and per-set status bits.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q         <= IDLE;
            write_q         <= 1'b0;
            tag_q           <= '0;
            index_q         <= '0;
            wdata_q         <= '0;
            wen_q           <= '0;
            victim_q        <= '0;
            victim_by_ptr_q <= 1'b0;
            resp_data_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        tag_q   <= req_addr[ADDR_W-1 -: TAG_W];
                        index_q <= req_addr[LOG_LINE_BYTES +: LOG_SETS];
                        wdata_q <= req_wdata;
                        wen_q   <= req_wen;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_data_q <= hit_result;
                        if (eff_write) dirty_q[index_q][hit_way] <= 1'b1;
                    end else begin
                        victim_q        <= victim_sel;
                        victim_by_ptr_q <= !inv_found;
                    end
                end
                WB_REQ: begin
                    if (mem_req_ready) dirty_q[index_q][victim_q] <= 1'b0;
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_q[index_q][victim_q] <= 1'b1;
                        dirty_q[index_q][victim_q] <= eff_write;
                        resp_data_q                <= fill_result;
                        if (victim_by_ptr_q) ptr_q[index_q] <= ptr_q[index_q] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data array writes on write hits and line fills.
    always_ff @(posedge clk) begin
        // NOTE: the arrays are not reset; cleared valid bits make their contents unreachable.
        if (reset_n && state_q == LOOKUP && hit && write_q) begin
            data_q[hit_way][index_q] <= hit_result;
        end
        if (reset_n && state_q == FILL_WAIT && mem_resp_valid) begin
            data_q[victim_q][index_q]    <= fill_result;
            tag_arr_q[victim_q][index_q] <= tag_q;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESPOND);
    assign resp_data     = resp_data_q;
    assign mem_req_valid = (state_q == WB_REQ) || (state_q == FILL_REQ);
    assign mem_req_write = (state_q == WB_REQ);
    assign mem_req_addr  = (state_q == WB_REQ) ? {victim_tag, index_q, {LOG_LINE_BYTES{1'b0}}}
                                               : {tag_q, index_q, {LOG_LINE_BYTES{1'b0}}};
    assign mem_req_data  = (state_q == WB_REQ) ? victim_line : '0;

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed stimulus for set_assoc_cache with a cycle-level
// memory responder inside the transaction task and hand-computed expectations.
module tb_set_assoc_cache;

    localparam int FILL_LAT = 3;

    logic         clk;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [63:0]  req_addr;
    logic [511:0] req_wdata;
    logic [7:0]   req_wen;
    logic         resp_valid;
    logic [511:0] resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic [63:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic         mem_resp_valid;
    logic [511:0] mem_resp_data;

    set_assoc_cache dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wen        (req_wen),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observations of the most recent transaction.
    int           n_wb;
    int           n_fill;
    int           lat;
    logic [511:0] resp_line;
    logic [63:0]  wb_addr;
    logic [511:0] wb_data;
    logic [63:0]  fill_addr;
    logic         wb_first;
    logic         stable_ok;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        req_valid      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Issue one request and service the memory side until resp_valid.
    task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [511:0] wd,
                           input logic [7:0] wen, input logic [511:0] fill_line, input int rdy_delay);
        int           wait_cnt;
        int           fill_cd;
        logic         snap;
        logic         s_wr;
        logic [63:0]  s_addr;
        logic [511:0] s_data;
        n_wb = 0; n_fill = 0; lat = -1; wb_first = 1'b0; stable_ok = 1'b1;
        resp_line = '0; wb_addr = '0; wb_data = '0; fill_addr = '0;
        wait_cnt = 0; fill_cd = 0; snap = 1'b0;
        s_wr = 1'b0; s_addr = '0; s_data = '0;
        @(negedge clk);
        check("req_ready_before_accept", req_ready, 1'b1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wen = wen;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            mem_resp_valid = 1'b0;
            if (resp_valid) begin
                lat       = i;
                resp_line = resp_data;
                break;
            end
            if (fill_cd > 0) begin
                fill_cd--;
                if (fill_cd == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = fill_line;
                end
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (snap && (mem_req_write !== s_wr || mem_req_addr !== s_addr ||
                             mem_req_data !== s_data)) stable_ok = 1'b0;
                if (wait_cnt < rdy_delay) begin
                    if (!snap) begin
                        snap = 1'b1; s_wr = mem_req_write; s_addr = mem_req_addr; s_data = mem_req_data;
                    end
                    wait_cnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    wait_cnt = 0;
                    snap = 1'b0;
                    if (mem_req_write) begin
                        n_wb++;
                        wb_addr = mem_req_addr;
                        wb_data = mem_req_data;
                    end else begin
                        if (n_fill == 0) wb_first = (n_wb > 0);
                        n_fill++;
                        fill_addr = mem_req_addr;
                        fill_cd   = FILL_LAT;
                    end
                end
            end
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("resp_valid_single_pulse", resp_valid, 1'b0);
    endtask

    task automatic expect_txn(input string tag, input logic [511:0] exp_line, input int exp_lat,
                              input int exp_wb, input int exp_fill, input logic [63:0] exp_faddr);
        check({tag, ".data"}, resp_line, exp_line);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".wb"}, n_wb, exp_wb);
        check({tag, ".fill"}, n_fill, exp_fill);
        if (exp_fill > 0) check({tag, ".faddr"}, fill_addr, exp_faddr);
    endtask

    logic [511:0] l_aa, l_m, l_wd, l_exp, l_bb, l_dd;
    logic [63:0]  w;

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wen = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = '0;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst.req_ready", req_ready, 1'b1);
        check("rst.resp_valid", resp_valid, 1'b0);
        check("rst.mem_req_valid", mem_req_valid, 1'b0);
        check("rst.mem_req_write", mem_req_write, 1'b0);
        check("rst.resp_data", resp_data, 512'h0);

        // Cold read, then a hit, then a single-word write hit.
        l_aa = {64{8'hAA}};
        run_txn(1'b0, 64'h1000, '0, 8'h00, l_aa, 0);
        expect_txn("A.cold_read", l_aa, 6, 0, 1, 64'h1000);
        run_txn(1'b0, 64'h1000, '0, 8'h00, '0, 0);
        expect_txn("A.read_hit", l_aa, 2, 0, 0, 64'h0);
        l_wd = {64{8'hFF}};
        l_wd[63:0] = 64'h1234;
        l_m = l_aa;
        l_m[63:0] = 64'h1234;
        run_txn(1'b1, 64'h1000, l_wd, 8'h01, '0, 0);
        expect_txn("A.write_hit", l_m, 2, 0, 0, 64'h0);

        // Fill the rest of set 0 through the invalid ways.
        run_txn(1'b0, 64'h0000, '0, 8'h00, {64{8'h10}}, 0);
        expect_txn("A.fill_way1", {64{8'h10}}, 6, 0, 1, 64'h0000);
        run_txn(1'b0, 64'h0800, '0, 8'h00, {64{8'h11}}, 0);
        expect_txn("A.fill_way2", {64{8'h11}}, 6, 0, 1, 64'h0800);
        run_txn(1'b0, 64'h1800, '0, 8'h00, {64{8'h13}}, 0);
        expect_txn("A.fill_way3", {64{8'h13}}, 6, 0, 1, 64'h1800);

        // Dirty eviction of way 0 with a four-cycle memory stall per request.
        run_txn(1'b0, 64'h2000, '0, 8'h00, {64{8'h14}}, 4);
        expect_txn("D.dirty_miss", {64{8'h14}}, 15, 1, 1, 64'h2000);
        check("D.wb_addr", wb_addr, 64'h1000);
        check("D.wb_data", wb_data, l_m);
        check("D.wb_before_fill", wb_first, 1'b1);
        check("D.outputs_stable", stable_ok, 1'b1);

        // Pointer now 1: way 1 (line 0x0) is the next victim.
        run_txn(1'b0, 64'h0000, '0, 8'h00, '0, 0);
        expect_txn("D.hit_way1", {64{8'h10}}, 2, 0, 0, 64'h0);
        run_txn(1'b0, 64'h2800, '0, 8'h00, {64{8'h15}}, 0);
        expect_txn("D.evict_way1", {64{8'h15}}, 6, 0, 1, 64'h2800);
        run_txn(1'b0, 64'h0000, '0, 8'h00, {64{8'h20}}, 0);
        expect_txn("D.refetch_0", {64{8'h20}}, 6, 0, 1, 64'h0000);
        run_txn(1'b0, 64'h1800, '0, 8'h00, '0, 0);
        expect_txn("D.hit_way3", {64{8'h13}}, 2, 0, 0, 64'h0);

        // Conflict misses from a clean reset: tags 0-4 in set 0.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            w = 64'hC0DE_0000_0000_0000 | 64'(t);
            run_txn(1'b0, 64'(t) * 64'h800, '0, 8'h00, {8{w}}, 0);
            expect_txn("C.conflict", {8{w}}, 6, 0, 1, 64'(t) * 64'h800);
        end
        run_txn(1'b0, 64'h0800, '0, 8'h00, '0, 0);
        expect_txn("C.tag1_hit", {8{64'hC0DE_0000_0000_0001}}, 2, 0, 0, 64'h0);
        run_txn(1'b0, 64'h0000, '0, 8'h00, {64{8'h30}}, 0);
        expect_txn("C.tag0_evicted", {64{8'h30}}, 6, 0, 1, 64'h0000);
        run_txn(1'b0, 64'h1000, '0, 8'h00, '0, 0);
        expect_txn("C.tag2_hit", {8{64'hC0DE_0000_0000_0002}}, 2, 0, 0, 64'h0);
        run_txn(1'b0, 64'h0800, '0, 8'h00, {64{8'h31}}, 0);
        expect_txn("C.tag1_evicted", {64{8'h31}}, 6, 0, 1, 64'h0800);

        // Write miss to set 1 merging word 7 only.
        l_bb = {64{8'hBB}};
        l_wd = {64'h5555_0000_0000_7777, {7{64'hDEAD_BEEF_0000_0001}}};
        l_exp = {64'h5555_0000_0000_7777, l_bb[447:0]};
        run_txn(1'b1, 64'h2040, l_wd, 8'h80, l_bb, 0);
        expect_txn("E.write_miss", l_exp, 6, 0, 1, 64'h2040);
        run_txn(1'b0, 64'h2040, '0, 8'h00, '0, 0);
        expect_txn("E.read_merged", l_exp, 2, 0, 0, 64'h0);
        run_txn(1'b0, 64'h0840, '0, 8'h00, {64{8'h41}}, 0);
        expect_txn("E.fill_w1", {64{8'h41}}, 6, 0, 1, 64'h0840);
        run_txn(1'b0, 64'h1040, '0, 8'h00, {64{8'h42}}, 0);
        expect_txn("E.fill_w2", {64{8'h42}}, 6, 0, 1, 64'h1040);
        run_txn(1'b0, 64'h1840, '0, 8'h00, {64{8'h43}}, 0);
        expect_txn("E.fill_w3", {64{8'h43}}, 6, 0, 1, 64'h1840);
        run_txn(1'b0, 64'h2840, '0, 8'h00, {64{8'h45}}, 0);
        expect_txn("E.evict_dirty", {64{8'h45}}, 7, 1, 1, 64'h2840);
        check("E.wb_addr", wb_addr, 64'h2040);
        check("E.wb_data", wb_data, l_exp);

        // Reset while waiting for a fill, then a stray fill response.
        @(negedge clk);
        check("F.req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h3000; req_wen = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !(mem_req_valid && !mem_req_write); i++) @(negedge clk);
        check("F.fill_req_seen", mem_req_valid && !mem_req_write, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("F.in_fill_wait", mem_req_valid, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n        = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {64{8'hEE}};
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("F.ready_after_reset", req_ready, 1'b1);
        check("F.no_resp", resp_valid, 1'b0);
        check("F.no_mem_req", mem_req_valid, 1'b0);
        l_dd = {64{8'hDD}};
        run_txn(1'b0, 64'h3000, '0, 8'h00, l_dd, 0);
        expect_txn("F.not_installed", l_dd, 6, 0, 1, 64'h3000);
        run_txn(1'b0, 64'h0840, '0, 8'h00, {64{8'h51}}, 0);
        expect_txn("F.set1_invalid", {64{8'h51}}, 6, 0, 1, 64'h0840);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
